// File: rtl/sdram_write_feeder.sv
// Buffers an upstream word stream and issues fixed-length SDRAM write bursts over a rolling address window.
// req rises one cycle after a full burst is buffered; in_ready drops only when the staging FIFO is full.
module sdram_write_feeder #(
   parameter int DQ_WIDTH     = 16,
   parameter int ADDR_WIDTH   = 24,
   parameter int BURST_LEN    = 8,
   parameter int FIFO_DEPTH   = 32,
   parameter int BASE_ADDR    = 0,
   parameter int REGION_WORDS = 65536
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic [DQ_WIDTH-1:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  restart,
   output logic                  req,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [8:0]            req_len,
   input  logic                  ack,
   output logic [DQ_WIDTH-1:0]   wr_data,
   input  logic                  wr_next,
   output logic                  burst_done,
   output logic                  underrun
);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int BW  = $clog2(BURST_LEN);
   localparam int AW1 = ADDR_WIDTH + 1;

   localparam logic [CW-1:0]         FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]         BURST_CNT = CW'(BURST_LEN);
   localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [AW1-1:0]        END_EXT   = AW1'(BASE_ADDR + REGION_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  done_q, done_d;
   logic                  underrun_q, underrun_d;
   logic                  pending_q, pending_d;
   logic [DQ_WIDTH-1:0]   mem_q [FIFO_DEPTH];

   logic                  push, pop, flush;
   logic [AW1-1:0]        addr_sum;
   logic [ADDR_WIDTH-1:0] addr_adv;

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      beat_d     = beat_q;
      addr_d     = addr_q;
      done_d     = 1'b0;
      underrun_d = underrun_q;
      pending_d  = pending_q;
      pop        = 1'b0;
      flush      = 1'b0;
      in_ready   = (count_q != FULL_CNT);

      addr_sum = {1'b0, addr_q} + AW1'(BURST_LEN);
      addr_adv = (addr_sum == END_EXT) ? BASE_A : addr_sum[ADDR_WIDTH-1:0];

      // A stray wr_next is flagged but never moves the FIFO or the FSM.
      if (wr_next) begin
         if (state_q == S_XFER && count_q != '0) begin
            pop = 1'b1;
         end else begin
            underrun_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (restart || pending_q) begin
               flush     = 1'b1;
               pending_d = 1'b0;
               addr_d    = BASE_A;
            end else if (count_q >= BURST_CNT) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (restart) pending_d = 1'b1;
            if (ack)     state_d   = S_XFER;
         end
         S_XFER: begin
            if (restart) pending_d = 1'b1;
            if (pop) begin
               beat_d = beat_q + BW'(1);
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  addr_d  = addr_adv;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      push = in_valid && in_ready && !flush;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         beat_q     <= '0;
         addr_q     <= BASE_A;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         beat_q     <= beat_d;
         addr_q     <= addr_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
         pending_q  <= pending_d;
      end
   end

   // Storage needs no reset: occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   assign req        = (state_q == S_REQ);
   assign req_addr   = addr_q;
   assign req_len    = 9'(BURST_LEN);
   assign wr_data    = mem_q[rd_ptr_q];
   assign burst_done = done_q;
   assign underrun   = underrun_q;
endmodule

// File: tb/tb_sdram_write_feeder.sv
// Randomized scoreboard bench for sdram_write_feeder; a queue-based reference model tracks FIFO contents and burst addresses.
module tb_sdram_write_feeder;
   localparam int DW     = 16;
   localparam int AW     = 24;
   localparam int BL     = 8;
   localparam int DEPTH  = 32;
   localparam int BASE   = 0;
   localparam int REGION = 16;

   logic          clk;
   logic          res;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          restart;
   logic          req;
   logic [AW-1:0] req_addr;
   logic [8:0]    req_len;
   logic          ack;
   logic [DW-1:0] wr_data;
   logic          wr_next;
   logic          burst_done;
   logic          underrun;

   int n_tests = 0;
   int n_fail  = 0;
   bit ctrl_done;

   sdram_write_feeder #(
      .DQ_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
      .BASE_ADDR(BASE), .REGION_WORDS(REGION)
   ) dut (
      .clk(clk), .res(res), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .restart(restart), .req(req), .req_addr(req_addr), .req_len(req_len), .ack(ack),
      .wr_data(wr_data), .wr_next(wr_next), .burst_done(burst_done), .underrun(underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words buffered, protocol phase, and bursts completed since reset/restart.
   logic [DW-1:0] mq[$];
   bit m_req, m_xfer, m_done, m_underrun, m_pending;
   int m_beats, m_bursts;
   int sz;
   bit idle, flush, acc, new_done;

   function automatic logic [31:0] exp_addr();
      return 32'(BASE + (m_bursts * BL) % REGION);
   endfunction

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (res) begin
            mq.delete();
            m_req = 0; m_xfer = 0; m_done = 0; m_underrun = 0; m_pending = 0;
            m_beats = 0; m_bursts = 0;
         end else begin
            sz = mq.size();
            chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
            chk("req", 32'(req), 32'(m_req));
            if (m_req) chk("req_addr", 32'(req_addr), exp_addr());
            chk("burst_done", 32'(burst_done), 32'(m_done));
            chk("underrun", 32'(underrun), 32'(m_underrun));

            idle     = !m_req && !m_xfer;
            flush    = idle && (restart || m_pending);
            acc      = in_valid && (sz != DEPTH);
            new_done = 0;
            if (restart && !idle) m_pending = 1;
            if (wr_next) begin
               if (m_xfer && sz > 0) begin
                  chk("wr_data", 32'(wr_data), 32'(mq[0]));
                  void'(mq.pop_front());
                  m_beats++;
                  if (m_beats == BL) begin
                     m_beats = 0; m_xfer = 0; new_done = 1; m_bursts++;
                  end
               end else begin
                  m_underrun = 1;
               end
            end
            if (m_req) begin
               if (ack) begin m_req = 0; m_xfer = 1; end
            end else if (idle && !flush && sz >= BL) begin
               m_req = 1;
            end
            if (flush) begin
               mq.delete(); m_bursts = 0; m_pending = 0;
            end else if (acc) begin
               mq.push_back(in_data);
            end
            m_done = new_done;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      int t;
      bit ok;
      t = 0;
      in_data  = w;
      in_valid = 1'b1;
      ok = in_ready;
      while (!ok && t < 500) begin
         step(); ok = in_ready; t++;
      end
      step();
      in_valid = 1'b0;
      chk("push_wait", 32'(ok), 32'd1);
   endtask

   // Emulates the controller: wait for req, grant it, then pull BL words with random gaps.
   task automatic do_burst(input bit hold_ack, input int ack_dly, input int gap_max,
                           input int restart_beat, input int abort_beat);
      int t;
      t = 0;
      while (req !== 1'b1 && t < 400) begin step(); t++; end
      chk("req_wait", 32'(req), 32'd1);
      if (req !== 1'b1) return;
      if (!hold_ack) repeat (ack_dly) step();
      ack = 1'b1;
      step();
      ack = hold_ack;
      for (int b = 0; b < BL; b++) begin
         if (b == abort_beat) begin
            res = 1'b1; step(); res = 1'b0; ack = 1'b0;
            chk("abort_req", 32'(req), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd1);
            chk("abort_addr", 32'(req_addr), 32'(BASE));
            chk("abort_done", 32'(burst_done), 32'd0);
            step();
            chk("abort_done_late", 32'(burst_done), 32'd0);
            return;
         end
         repeat ($urandom_range(0, gap_max)) step();
         wr_next = 1'b1;
         restart = (b == restart_beat);
         step();
         wr_next = 1'b0;
         restart = 1'b0;
      end
      ack = 1'b0;
   endtask

   initial begin : stim
      res = 1'b1; in_valid = 1'b0; in_data = '0; restart = 1'b0; ack = 1'b0; wr_next = 1'b0;
      repeat (3) @(posedge clk);
      #1 res = 1'b0;
      step();
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_done", 32'(burst_done), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_addr", 32'(req_addr), 32'(BASE));
      chk("req_len", 32'(req_len), 32'(BL));

      // Single burst at address 0 with ack held high.
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      do_burst(1'b1, 0, 0, -1, -1);
      repeat (3) step();

      // Fill to full with no grant; the 33rd word must wait.
      for (int i = 0; i < 32; i++) push_word(DW'(16'h0100 + i));
      in_data = 16'h0133; in_valid = 1'b1;
      repeat (6) step();
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_req", 32'(req), 32'd1);
      chk("full_addr", 32'(req_addr), 32'd8);
      fork
         push_word(16'h0133);
         do_burst(1'b0, 2, 2, -1, -1);
      join
      repeat (3) do_burst(1'b0, int'($urandom_range(0, 3)), 2, -1, -1);
      repeat (3) step();

      // Stray wr_next while idle: sticky flag, no pop (0x0133 must still lead the next burst).
      wr_next = 1'b1; step(); wr_next = 1'b0;
      repeat (3) step();
      chk("underrun_sticky", 32'(underrun), 32'd1);
      for (int i = 0; i < 7; i++) push_word(DW'(16'h0140 + i));
      do_burst(1'b0, 1, 1, -1, -1);
      repeat (2) step();
      chk("underrun_held", 32'(underrun), 32'd1);
      res = 1'b1; step(); res = 1'b0;
      chk("underrun_cleared", 32'(underrun), 32'd0);

      // Restart during the burst at address 8: leftover words flushed, address rewinds.
      for (int i = 0; i < 20; i++) push_word(DW'(16'h0200 + i));
      do_burst(1'b1, 0, 1, -1, -1);
      do_burst(1'b0, 1, 1, 2, -1);
      repeat (4) step();
      for (int i = 0; i < 8; i++) push_word(DW'(16'h0300 + i));
      repeat (2) step();
      chk("restart_req", 32'(req), 32'd1);
      chk("restart_addr", 32'(req_addr), 32'(BASE));
      do_burst(1'b0, 0, 1, -1, -1);
      repeat (3) step();

      // Reset mid-transfer after three pops.
      for (int i = 0; i < 8; i++) push_word(DW'(16'h0400 + i));
      do_burst(1'b0, 0, 1, -1, 3);
      repeat (3) step();

      // Random traffic with concurrent pushes, random grants/gaps and occasional restarts.
      ctrl_done = 1'b0;
      fork
         begin
            while (!ctrl_done) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_data  = DW'($urandom);
               step();
            end
            in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 40; k++) begin
               if ($urandom_range(0, 5) == 0) begin
                  restart = 1'b1; step(); restart = 1'b0;
               end
               do_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 3)),
                        ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
            end
            ctrl_done = 1'b1;
         end
      join
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
